// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage sitting behind the PC generator. Issues in-order
//   reads to instruction memory, tracks the PC of every outstanding request,
//   and queues {pc, inst} pairs for decode. Redirects (flush_i) clear the
//   output queue and turn every in-flight response into a drop.
//
// Parameters
//   FIFO_DEPTH       output queue depth (power of two, >= 2)
//   MAX_OUTSTANDING  max memory requests in flight (>= 1, <= FIFO_DEPTH)
//
// Ports
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   pc_i, pc_valid_i               current PC from the PC generator
//   flush_i                        jump/branch redirect
//   stage_IF_ready_o               fetch of pc_i accepted (PC may advance)
//   imem_req_valid_o/addr_o/ready_i  memory read request channel
//   imem_rsp_valid_i/data_i        in-order memory read responses
//   id_valid_o/pc_o/inst_o/ready_i decode-side output queue head
//   id_misalign_o                  head entry is a misaligned-PC marker
//                                  (only with IF_MISALIGN_CHECK_EN)
//
// Configuration
//   IF_MISALIGN_CHECK_EN  when defined, a PC with pc_i[1:0] != 0 issues no
//                         memory read; a {pc, 0} entry flagged misaligned is
//                         queued instead once the stage has drained.
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    input  logic        flush_i,
    output logic        stage_IF_ready_o,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
`ifdef IF_MISALIGN_CHECK_EN
    output logic        id_misalign_o,
`endif
    input  logic        id_ready_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Pending-PC queue: PC of each request still waiting for its response.
    logic [31:0]   pend_pc_q [MAX_OUTSTANDING];
    logic [PW-1:0] pend_wr_q, pend_rd_q;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;

    // Output queue.
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_inst_q [FIFO_DEPTH];
    logic          fifo_mis_q  [FIFO_DEPTH];
    logic [AW-1:0] fifo_wr_q, fifo_rd_q;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic        credit, req_fire, rsp_fire, fifo_push, fifo_pop;
    logic        mis_push;
    logic [31:0] push_pc, push_inst;

    function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Every outstanding request owns a future output slot, so the queue
    // cannot overflow when its response lands.
    assign credit = ((32'(outstanding_q) + 32'(fifo_cnt_q)) < FIFO_DEPTH) &&
                    (32'(outstanding_q) < MAX_OUTSTANDING);

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign;
    assign misalign         = pc_valid_i && (pc_i[1:0] != 2'b00);
    // Wait for all in-flight reads so the marker stays in program order.
    assign mis_push         = misalign && !flush_i && (outstanding_q == '0) &&
                              (32'(fifo_cnt_q) < FIFO_DEPTH);
    assign imem_req_valid_o = pc_valid_i && !misalign && credit && !flush_i;
    assign id_misalign_o    = id_valid_o && fifo_mis_q[fifo_rd_q];
`else
    assign mis_push         = 1'b0;
    assign imem_req_valid_o = pc_valid_i && credit && !flush_i;
`endif

    assign imem_req_addr_o  = pc_i;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign stage_IF_ready_o = req_fire || mis_push;

    // Ignore stray responses with nothing in flight.
    assign rsp_fire  = imem_rsp_valid_i && (outstanding_q != '0);
    assign fifo_push = (rsp_fire && (drop_cnt_q == '0) && !flush_i) || mis_push;
    assign fifo_pop  = id_valid_o && id_ready_i;
    assign push_pc   = mis_push ? pc_i : pend_pc_q[pend_rd_q];
    assign push_inst = mis_push ? 32'h0 : imem_rsp_data_i;

    assign id_valid_o = (fifo_cnt_q != '0);
    assign id_pc_o    = id_valid_o ? fifo_pc_q[fifo_rd_q]   : 32'h0;
    assign id_inst_o  = id_valid_o ? fifo_inst_q[fifo_rd_q] : 32'h0;

    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!req_fire && rsp_fire) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        // On flush every request still in flight becomes a drop; a response
        // arriving in the flush cycle is discarded directly.
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            drop_cnt_d = rsp_fire ? outstanding_q - 1'b1 : outstanding_q;
        end else if (rsp_fire && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end

        fifo_cnt_d = fifo_cnt_q;
        if (flush_i) begin
            fifo_cnt_d = '0;
        end else if (fifo_push && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            if (req_fire) pend_wr_q <= pend_next(pend_wr_q);
            if (rsp_fire) pend_rd_q <= pend_next(pend_rd_q);
            if (flush_i) begin
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
            end else begin
                if (fifo_push) fifo_wr_q <= fifo_wr_q + 1'b1;
                if (fifo_pop)  fifo_rd_q <= fifo_rd_q + 1'b1;
            end
        end
    end

    // Storage arrays need no reset: outputs are gated by the queue count.
    always_ff @(posedge clk_i) begin
        if (req_fire) pend_pc_q[pend_wr_q] <= pc_i;
        if (fifo_push) begin
            fifo_pc_q[fifo_wr_q]   <= push_pc;
            fifo_inst_q[fifo_wr_q] <= push_inst;
            fifo_mis_q[fifo_wr_q]  <= mis_push;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        flush_i;
    logic        stage_IF_ready_o;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;
`ifdef IF_MISALIGN_CHECK_EN
    logic        id_misalign_o;
`endif

    always #5 clk = ~clk;

    if_fetch_stage #(
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .pc_i             (pc_i),
        .pc_valid_i       (pc_valid_i),
        .flush_i          (flush_i),
        .stage_IF_ready_o (stage_IF_ready_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .id_valid_o       (id_valid_o),
        .id_pc_o          (id_pc_o),
        .id_inst_o        (id_inst_o),
`ifdef IF_MISALIGN_CHECK_EN
        .id_misalign_o    (id_misalign_o),
`endif
        .id_ready_i       (id_ready_i)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] memq[$];
    bit          mem_hold = 1'b0;
    bit          auto_pc  = 1'b0;
    logic [31:0] pc_last  = 32'h0;
    int          req_count = 0;
    int          rc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory answers one cycle after acceptance, in order, unless held.
    task automatic mem_present();
        imem_rsp_valid_i = !mem_hold && (memq.size() > 0);
        imem_rsp_data_i  = imem_rsp_valid_i ? mem_word(memq[0]) : 32'h0;
    endtask

    // One clock: sample handshakes mid-cycle, update stimulus after the edge.
    task automatic tick();
        logic        fire, rdy, rsp;
        logic [31:0] addr;
        @(negedge clk);
        fire = imem_req_valid_o && imem_req_ready_i;
        addr = imem_req_addr_o;
        rdy  = stage_IF_ready_o;
        rsp  = imem_rsp_valid_i;
        @(posedge clk);
        #1;
        if (rsp) void'(memq.pop_front());
        if (fire) begin
            memq.push_back(addr);
            req_count++;
        end
        if (auto_pc && rdy) begin
            if (pc_i == pc_last) pc_valid_i = 1'b0;
            else                 pc_i = pc_i + 32'd4;
        end
        mem_present();
        #1;
    endtask

    // Expect n consecutive sequential PCs from 'first' to reach decode.
    task automatic drain(input string tag, input int n, input logic [31:0] first,
                         input int budget);
        logic [31:0] exp;
        int          got;
        exp = first;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (id_valid_o && id_ready_i) begin
                chk({tag, "_pc"}, id_pc_o, exp);
                chk({tag, "_inst"}, id_inst_o, mem_word(exp));
                exp = exp + 32'd4;
                got++;
            end
            tick();
        end
        chk({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i          = 1'b1;
        pc_i             = 32'h0;
        pc_valid_i       = 1'b0;
        flush_i          = 1'b0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        id_ready_i       = 1'b1;
        tick();
        tick();
        chk("rst_id_valid", 32'(id_valid_o), 32'd0);
        chk("rst_id_pc", id_pc_o, 32'h0);
        chk("rst_id_inst", id_inst_o, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_if_ready", 32'(stage_IF_ready_o), 32'd0);
        reset_i = 1'b0;

        // 1: three sequential fetches, one delivered per cycle.
        pc_i = 32'h100; pc_last = 32'h108; pc_valid_i = 1'b1; auto_pc = 1'b1;
        #1;
        chk("t1_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("t1_req_addr", imem_req_addr_o, 32'h100);
        chk("t1_if_ready", 32'(stage_IF_ready_o), 32'd1);
        tick();
        chk("t1_lat_valid", 32'(id_valid_o), 32'd0);
        tick();
        chk("t1_v0", 32'(id_valid_o), 32'd1);
        chk("t1_pc0", id_pc_o, 32'h100);
        chk("t1_inst0", id_inst_o, mem_word(32'h100));
        tick();
        chk("t1_v1", 32'(id_valid_o), 32'd1);
        chk("t1_pc1", id_pc_o, 32'h104);
        chk("t1_inst1", id_inst_o, mem_word(32'h104));
        tick();
        chk("t1_v2", 32'(id_valid_o), 32'd1);
        chk("t1_pc2", id_pc_o, 32'h108);
        chk("t1_inst2", id_inst_o, mem_word(32'h108));
        tick();
        chk("t1_empty", 32'(id_valid_o), 32'd0);

        // 2: decode stalled, queue fills to exactly FIFO_DEPTH.
        rc = req_count;
        id_ready_i = 1'b0;
        pc_i = 32'h500; pc_last = 32'h51C; pc_valid_i = 1'b1;
        #1;
        repeat (10) tick();
        chk("t2_full_valid", 32'(id_valid_o), 32'd1);
        chk("t2_head_pc", id_pc_o, 32'h500);
        chk("t2_if_ready", 32'(stage_IF_ready_o), 32'd0);
        chk("t2_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("t2_pc_held", pc_i, 32'h510);
        chk("t2_req_cnt", 32'(req_count - rc), 32'd4);
        id_ready_i = 1'b1;
        #1;
        drain("t2_drain", 8, 32'h500, 60);
        chk("t2_req_total", 32'(req_count - rc), 32'd8);

        // 3: flush with two requests in flight.
        rc = req_count;
        mem_hold = 1'b1;
        pc_i = 32'h200; pc_last = 32'h204; pc_valid_i = 1'b1;
        #1;
        tick();
        tick();
        chk("t3_issued", 32'(req_count - rc), 32'd2);
        pc_i = 32'h208; pc_valid_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("t3_flush_req", 32'(imem_req_valid_o), 32'd0);
        chk("t3_flush_rdy", 32'(stage_IF_ready_o), 32'd0);
        tick();
        flush_i = 1'b0; pc_i = 32'h400; pc_last = 32'h400; pc_valid_i = 1'b1;
        mem_hold = 1'b0;
        mem_present();
        #1;
        chk("t3_post_valid", 32'(id_valid_o), 32'd0);
        drain("t3_target", 1, 32'h400, 20);
        repeat (3) tick();
        chk("t3_idle", 32'(id_valid_o), 32'd0);

        // 4: flush in the same cycle as the response for 0x300.
        mem_hold = 1'b1;
        pc_i = 32'h300; pc_last = 32'h304; pc_valid_i = 1'b1;
        #1;
        tick();
        tick();
        mem_hold = 1'b0;
        mem_present();
        flush_i = 1'b1;
        #1;
        chk("t4_rsp_0x300", imem_rsp_data_i, mem_word(32'h300));
        chk("t4_flush_req", 32'(imem_req_valid_o), 32'd0);
        tick();
        flush_i = 1'b0; pc_i = 32'h600; pc_last = 32'h600; pc_valid_i = 1'b1;
        #1;
        chk("t4_post_valid", 32'(id_valid_o), 32'd0);
        drain("t4_target", 1, 32'h600, 20);
        repeat (3) tick();
        chk("t4_idle", 32'(id_valid_o), 32'd0);

        // 5: memory back-pressure holds the PC without duplicate fetches.
        rc = req_count;
        imem_req_ready_i = 1'b0;
        pc_i = 32'h700; pc_last = 32'h704; pc_valid_i = 1'b1;
        #1;
        repeat (3) begin
            chk("t5_req_valid", 32'(imem_req_valid_o), 32'd1);
            chk("t5_if_ready", 32'(stage_IF_ready_o), 32'd0);
            chk("t5_pc_held", pc_i, 32'h700);
            tick();
        end
        imem_req_ready_i = 1'b1;
        #1;
        drain("t5_drain", 2, 32'h700, 20);
        chk("t5_req_cnt", 32'(req_count - rc), 32'd2);

`ifdef IF_MISALIGN_CHECK_EN
        // 6: misaligned PC produces a marker entry, no memory read.
        rc = req_count;
        pc_i = 32'h102; pc_last = 32'h102; pc_valid_i = 1'b1;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("t6_if_ready", 32'(stage_IF_ready_o), 32'd1);
        tick();
        chk("t6_valid", 32'(id_valid_o), 32'd1);
        chk("t6_pc", id_pc_o, 32'h102);
        chk("t6_inst", id_inst_o, 32'h0);
        chk("t6_misalign", 32'(id_misalign_o), 32'd1);
        tick();
        chk("t6_empty", 32'(id_valid_o), 32'd0);
        chk("t6_mis_clear", 32'(id_misalign_o), 32'd0);
        chk("t6_no_req", 32'(req_count - rc), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
